screen_line_fetcher: RTL and testbench
======================================

Name: screen_line_fetcher

Overview:
- Shares the single RAM data port between the CPU (always wins) and a screen-row prefetcher, so the VGA path no longer needs a dedicated RAM read port.
- On each row request it copies WORDS_PER_ROW consecutive words of screen memory into a back buffer during cycles the CPU leaves idle.
- The back buffer is swapped into a front buffer, which the VGA pixel/hex logic reads combinationally.

Parameters:
- DATA_WIDTH, 16, RAM word width.
- ADDR_WIDTH, 9, RAM address width; all address arithmetic wraps modulo 2**ADDR_WIDTH.
- WORDS_PER_ROW, 2, words fetched per screen row; legal range 1..32.
- SCREEN_BASE, 0, RAM address of screen row 0, word 0.
- ROW_WIDTH, 5, width of the row index.

Ports:
- CLK_50  in  1  system clock; all state updates on rising edge.
- resetN  in  1  synchronous active-low reset.
- cpu_req  in  1  CPU drives a RAM access this cycle.
- cpu_we  in  1  CPU write enable; ignored when cpu_req=0.
- cpu_addr  in  ADDR_WIDTH  CPU address.
- cpu_wdata  in  DATA_WIDTH  CPU write data.
- cpu_rdata  out  DATA_WIDTH  equals ram_rdata (RAM read latency 1 cycle).
- ram_addr  out  ADDR_WIDTH  shared RAM port address.
- ram_we  out  1  shared RAM port write enable.
- ram_wdata  out  DATA_WIDTH  shared RAM port write data.
- ram_rdata  in  DATA_WIDTH  RAM read data, valid the cycle after the address is presented.
- line_start  in  1  one-cycle pulse: commit the fetched row, then fetch row `row`.
- row  in  ROW_WIDTH  row index, sampled with line_start.
- buf_idx  in  5  front-buffer word select.
- buf_rdata  out  DATA_WIDTH  front[buf_idx], combinational; 0 if buf_idx >= WORDS_PER_ROW.
- busy  out  1  fetch in progress.
- done  out  1  one-cycle pulse when the last word is captured.
- overrun  out  1  sticky: a line_start arrived while busy.

Behaviour:
- Reset (resetN=0 at a clock edge):
  - State is IDLE; front and back buffers are all 0.
  - back_valid=0, busy=0, done=0, overrun=0, issue and capture counters are 0, pending=0.
  - ram_we is forced 0 combinationally while resetN=0.
  - Reset mid-fetch abandons the fetch; no partial commit.
- Port mux (combinational):
  - cpu_req=1: ram_addr=cpu_addr, ram_we=cpu_we, ram_wdata=cpu_wdata.
  - Otherwise, if the state is FETCH and issue count < WORDS_PER_ROW: ram_addr=fetch address, ram_we=0; the issue counter increments and pending=1 next cycle.
  - Otherwise ram_addr=0, ram_we=0.
  - The CPU is never stalled.
- Fetch address for word i = (SCREEN_BASE + row_q*WORDS_PER_ROW + i) mod 2**ADDR_WIDTH. row_q is row latched at line_start.
- Capture: when pending=1, back[capture count] <= ram_rdata and the capture counter increments. pending follows the previous cycle's fetch issue only, so CPU reads are never captured.
- States:
  - IDLE --line_start--> FETCH.
  - FETCH --last capture--> IDLE, with done=1 that cycle, back_valid=1, busy=0.
  - busy=1 exactly while in FETCH.
- line_start handling, in order within one cycle:
  1. If a final capture also occurs this cycle, it completes first and counts.
  2. If back_valid=1, front<=back and back_valid<=0; otherwise front is unchanged.
  3. If busy (and not completing this cycle), overrun<=1 and the partial back contents are discarded.
  4. Latch row_q, zero the counters and pending, enter FETCH.
- Latency with CPU idle (line_start sampled at edge 0):
  - Address for word k is issued in cycle k+1.
  - Captured at edge k+2.
  - done is asserted in the cycle after the last issue (cycle WORDS_PER_ROW+1).
- CPU traffic inserts one cycle of delay per cpu_req cycle; continuous cpu_req stalls the fetch indefinitely with busy held at 1.
- Row wrap: row=2**ROW_WIDTH-1 with large WORDS_PER_ROW wraps the address modulo 2**ADDR_WIDTH.

Test Plan:
- Reset, RAM[0..3]=16'h1111,2222,3333,4444; line_start row=1, cpu_req=0 -> ram_addr 2 then 3 in cycles 1..2. done in cycle 3. Second line_start row=0 -> buf_rdata idx0=16'h3333, idx1=16'h4444.
- cpu_req=1 (read addr 7) during cycles 1-3 of a fetch of row 0 -> ram_addr=7 in those cycles; fetch addrs 0,1 issued in cycles 4,5; done in cycle 6; back holds RAM[0..1] unpolluted.
- line_start at cycle 2 of a fetch -> overrun=1 and stays 1; front unchanged; new fetch starts from word 0 of the new row.
- line_start coincident with the final capture -> no overrun; front gets the just-completed row.
- resetN=0 mid-fetch -> busy=0, done=0, buffers 0, ram_we=0 during reset even with cpu_we=1; buf_idx=5 -> buf_rdata=0.
- ADDR_WIDTH=9, SCREEN_BASE=510, row=1, WORDS_PER_ROW=2 -> fetch addrs 0 then 1 (wrap).

Source files
------------

// File: rtl/screen_line_fetcher.sv
// Shares one RAM port between the CPU (always wins) and a screen-row prefetcher into a back/front buffer pair.
// Word k of a row is issued in cycle k+1 after line_start and captured one cycle later; each cpu_req cycle delays the fetch by one cycle.
module screen_line_fetcher #(
  parameter int DATA_WIDTH    = 16,
  parameter int ADDR_WIDTH    = 9,
  parameter int WORDS_PER_ROW = 2,
  parameter int SCREEN_BASE   = 0,
  parameter int ROW_WIDTH     = 5
) (
  input  logic                  CLK_50,
  input  logic                  resetN,
  input  logic                  cpu_req,
  input  logic                  cpu_we,
  input  logic [ADDR_WIDTH-1:0] cpu_addr,
  input  logic [DATA_WIDTH-1:0] cpu_wdata,
  output logic [DATA_WIDTH-1:0] cpu_rdata,
  output logic [ADDR_WIDTH-1:0] ram_addr,
  output logic                  ram_we,
  output logic [DATA_WIDTH-1:0] ram_wdata,
  input  logic [DATA_WIDTH-1:0] ram_rdata,
  input  logic                  line_start,
  input  logic [ROW_WIDTH-1:0]  row,
  input  logic [4:0]            buf_idx,
  output logic [DATA_WIDTH-1:0] buf_rdata,
  output logic                  busy,
  output logic                  done,
  output logic                  overrun
);

  localparam int CW = $clog2(WORDS_PER_ROW + 1);
  localparam logic [CW-1:0] NWORDS   = CW'(WORDS_PER_ROW);
  localparam logic [CW-1:0] LAST_IDX = CW'(WORDS_PER_ROW - 1);

  typedef enum logic {ST_IDLE, ST_FETCH} state_t;

  state_t                state_q, state_d;
  logic [ROW_WIDTH-1:0]  row_q, row_d;
  logic [CW-1:0]         issue_cnt_q, issue_cnt_d;
  logic [CW-1:0]         cap_cnt_q, cap_cnt_d;
  logic                  pending_q, pending_d;
  logic                  back_valid_q, back_valid_d;
  logic                  overrun_q, overrun_d;
  logic [DATA_WIDTH-1:0] back_q  [WORDS_PER_ROW];
  logic [DATA_WIDTH-1:0] back_d  [WORDS_PER_ROW];
  logic [DATA_WIDTH-1:0] front_q [WORDS_PER_ROW];
  logic [DATA_WIDTH-1:0] front_d [WORDS_PER_ROW];

  logic                  fetch_issue;
  logic                  final_cap;
  logic [ADDR_WIDTH-1:0] fetch_addr;

  // Each term is truncated to ADDR_WIDTH so the sum wraps modulo 2**ADDR_WIDTH.
  assign fetch_addr = ADDR_WIDTH'(SCREEN_BASE)
                    + ADDR_WIDTH'(row_q * WORDS_PER_ROW)
                    + ADDR_WIDTH'(issue_cnt_q);

  assign final_cap = pending_q && (cap_cnt_q == LAST_IDX);
  assign busy      = (state_q == ST_FETCH);
  assign done      = final_cap;
  assign overrun   = overrun_q;
  assign cpu_rdata = ram_rdata;

  always_comb begin
    fetch_issue = 1'b0;
    ram_addr    = '0;
    ram_we      = 1'b0;
    ram_wdata   = '0;
    if (cpu_req) begin
      ram_addr  = cpu_addr;
      ram_we    = cpu_we & resetN;
      ram_wdata = cpu_wdata;
    end else if ((state_q == ST_FETCH) && (issue_cnt_q < NWORDS)) begin
      fetch_issue = 1'b1;
      ram_addr    = fetch_addr;
    end
  end

  always_comb begin
    state_d      = state_q;
    row_d        = row_q;
    issue_cnt_d  = issue_cnt_q;
    cap_cnt_d    = cap_cnt_q;
    back_valid_d = back_valid_q;
    overrun_d    = overrun_q;
    back_d       = back_q;
    front_d      = front_q;
    // pending tracks only the fetch slot, so CPU read data is never captured.
    pending_d    = fetch_issue;

    if (fetch_issue) begin
      issue_cnt_d = issue_cnt_q + 1'b1;
    end

    if (pending_q) begin
      for (int i = 0; i < WORDS_PER_ROW; i++) begin
        if (cap_cnt_q == CW'(i)) begin
          back_d[i] = ram_rdata;
        end
      end
      cap_cnt_d = cap_cnt_q + 1'b1;
    end

    if (final_cap) begin
      state_d      = ST_IDLE;
      back_valid_d = 1'b1;
    end

    // A row completing in this same cycle is committed before the restart.
    if (line_start) begin
      if (back_valid_d) begin
        front_d      = back_d;
        back_valid_d = 1'b0;
      end
      if ((state_q == ST_FETCH) && !final_cap) begin
        overrun_d = 1'b1;
      end
      row_d       = row;
      issue_cnt_d = '0;
      cap_cnt_d   = '0;
      pending_d   = 1'b0;
      state_d     = ST_FETCH;
    end
  end

  always_ff @(posedge CLK_50) begin
    if (!resetN) begin
      state_q      <= ST_IDLE;
      row_q        <= '0;
      issue_cnt_q  <= '0;
      cap_cnt_q    <= '0;
      pending_q    <= 1'b0;
      back_valid_q <= 1'b0;
      overrun_q    <= 1'b0;
      for (int i = 0; i < WORDS_PER_ROW; i++) begin
        back_q[i]  <= '0;
        front_q[i] <= '0;
      end
    end else begin
      state_q      <= state_d;
      row_q        <= row_d;
      issue_cnt_q  <= issue_cnt_d;
      cap_cnt_q    <= cap_cnt_d;
      pending_q    <= pending_d;
      back_valid_q <= back_valid_d;
      overrun_q    <= overrun_d;
      back_q       <= back_d;
      front_q      <= front_d;
    end
  end

  always_comb begin
    buf_rdata = '0;
    for (int i = 0; i < WORDS_PER_ROW; i++) begin
      if (buf_idx == 5'(i)) begin
        buf_rdata = front_q[i];
      end
    end
  end

endmodule

// File: tb/tb_screen_line_fetcher.sv
// Directed bench: two fetchers (base 0 and base 510) on a shared 512-word RAM model with 1-cycle read latency.
module tb_screen_line_fetcher;

  logic        clk = 1'b0;
  logic        resetN;
  logic        cpu_req, cpu_we;
  logic [8:0]  cpu_addr;
  logic [15:0] cpu_wdata;
  logic        line_start;
  logic [4:0]  row;
  logic [4:0]  buf_idx;

  logic [15:0] cpu_rdata, ram_wdata, buf_rdata;
  logic [8:0]  ram_addr;
  logic        ram_we, busy, done, overrun;
  logic [15:0] ram_rdata;

  logic [15:0] cpu_rdata2, ram_wdata2, buf_rdata2;
  logic [8:0]  ram_addr2;
  logic        ram_we2, busy2, done2, overrun2;
  logic [15:0] ram_rdata2;

  logic [15:0] mem [512];

  int n_total = 0;
  int n_bad   = 0;

  always #5 clk = ~clk;

  screen_line_fetcher dut (
    .CLK_50(clk), .resetN(resetN),
    .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
    .cpu_rdata(cpu_rdata),
    .ram_addr(ram_addr), .ram_we(ram_we), .ram_wdata(ram_wdata), .ram_rdata(ram_rdata),
    .line_start(line_start), .row(row), .buf_idx(buf_idx), .buf_rdata(buf_rdata),
    .busy(busy), .done(done), .overrun(overrun)
  );

  screen_line_fetcher #(.SCREEN_BASE(510)) dut_wrap (
    .CLK_50(clk), .resetN(resetN),
    .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
    .cpu_rdata(cpu_rdata2),
    .ram_addr(ram_addr2), .ram_we(ram_we2), .ram_wdata(ram_wdata2), .ram_rdata(ram_rdata2),
    .line_start(line_start), .row(row), .buf_idx(buf_idx), .buf_rdata(buf_rdata2),
    .busy(busy2), .done(done2), .overrun(overrun2)
  );

  always @(posedge clk) begin
    if (ram_we) mem[ram_addr] <= ram_wdata;
    ram_rdata  <= mem[ram_addr];
    ram_rdata2 <= mem[ram_addr2];
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic smp();
    @(negedge clk);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1);
  end

  initial begin
    for (int i = 0; i < 512; i++) mem[i] = 16'hA000 + 16'(i);
    mem[0] = 16'h1111; mem[1] = 16'h2222; mem[2] = 16'h3333; mem[3] = 16'h4444;
    resetN = 1'b0; cpu_req = 1'b1; cpu_we = 1'b1; cpu_addr = 9'd5; cpu_wdata = 16'hDEAD;
    line_start = 1'b0; row = '0; buf_idx = '0;

    cyc(); cyc(); smp();
    check("rst_we", 32'(ram_we), 0);
    check("rst_we_wrap", 32'(ram_we2), 0);
    check("rst_cpu_addr", 32'(ram_addr), 5);
    check("rst_busy", 32'(busy), 0);
    check("rst_done", 32'(done), 0);
    check("rst_overrun", 32'(overrun), 0);
    check("rst_buf", 32'(buf_rdata), 0);
    cyc(); resetN = 1'b1; cpu_req = 1'b0; cpu_we = 1'b0;

    // Row 1 fetch, CPU idle; wrap instance fetches 510+2 -> 0, 1.
    cyc(); line_start = 1'b1; row = 5'd1;
    cyc(); line_start = 1'b0;
    smp(); check("t1_addr0", 32'(ram_addr), 2); check("t1_busy", 32'(busy), 1);
    check("wrap_addr0", 32'(ram_addr2), 0);
    cyc(); smp(); check("t1_addr1", 32'(ram_addr), 3); check("t1_done_early", 32'(done), 0);
    check("wrap_addr1", 32'(ram_addr2), 1);
    cyc(); smp(); check("t1_done", 32'(done), 1); check("t1_idle_addr", 32'(ram_addr), 0);
    check("wrap_done", 32'(done2), 1);
    cyc(); smp(); check("t1_busy_end", 32'(busy), 0); check("t1_front_old", 32'(buf_rdata), 0);

    // Commit row 1, fetch row 0.
    cyc(); line_start = 1'b1; row = 5'd0;
    cyc(); line_start = 1'b0;
    smp(); check("t1_front0", 32'(buf_rdata), 32'h3333);
    buf_idx = 5'd1; #1 check("t1_front1", 32'(buf_rdata), 32'h4444);
    buf_idx = 5'd5; #1 check("t1_idx_oob", 32'(buf_rdata), 0);
    buf_idx = 5'd0;
    check("t1b_addr0", 32'(ram_addr), 0);
    cyc(); cyc(); cyc();

    // Row 0 fetch with CPU reads of address 7 in cycles 1..3.
    line_start = 1'b1; row = 5'd0;
    cyc(); line_start = 1'b0; cpu_req = 1'b1; cpu_addr = 9'd7;
    smp(); check("t2_cpu_c1", 32'(ram_addr), 7); check("t2_front0", 32'(buf_rdata), 32'h1111);
    cyc(); smp(); check("t2_cpu_c2", 32'(ram_addr), 7);
    cyc(); smp(); check("t2_cpu_c3", 32'(ram_addr), 7); check("t2_cpu_rdata", 32'(cpu_rdata), 32'hA007);
    check("t2_done_c3", 32'(done), 0);
    cyc(); cpu_req = 1'b0;
    smp(); check("t2_addr_c4", 32'(ram_addr), 0);
    cyc(); smp(); check("t2_addr_c5", 32'(ram_addr), 1); check("t2_done_c5", 32'(done), 0);
    cyc(); smp(); check("t2_done_c6", 32'(done), 1);

    // Row 1 fetch with line_start landing on the final capture.
    cyc(); line_start = 1'b1; row = 5'd1;
    cyc(); line_start = 1'b0;
    smp(); check("t4_addr0", 32'(ram_addr), 2); check("t2_unpolluted", 32'(buf_rdata), 32'h1111);
    buf_idx = 5'd1; #1 check("t2_unpolluted1", 32'(buf_rdata), 32'h2222); buf_idx = 5'd0;
    cyc(); smp(); check("t4_addr1", 32'(ram_addr), 3);
    cyc(); line_start = 1'b1; row = 5'd0;
    smp(); check("t4_done", 32'(done), 1);
    cyc(); line_start = 1'b0;
    smp(); check("t4_no_overrun", 32'(overrun), 0); check("t4_front0", 32'(buf_rdata), 32'h3333);
    buf_idx = 5'd1; #1 check("t4_front1", 32'(buf_rdata), 32'h4444); buf_idx = 5'd0;
    check("t4_restart_addr", 32'(ram_addr), 0); check("t4_busy", 32'(busy), 1);

    // Interrupt the row 0 fetch in its cycle 2 with row 1.
    cyc(); line_start = 1'b1; row = 5'd1;
    smp(); check("t3_pre_overrun", 32'(overrun), 0);
    cyc(); line_start = 1'b0;
    smp(); check("t3_overrun", 32'(overrun), 1); check("t3_restart_addr", 32'(ram_addr), 2);
    check("t3_front_kept", 32'(buf_rdata), 32'h3333);
    cyc(); smp(); check("t3_addr1", 32'(ram_addr), 3);
    cyc(); smp(); check("t3_done", 32'(done), 1);
    cyc(); smp(); check("t3_busy_end", 32'(busy), 0); check("t3_sticky", 32'(overrun), 1);

    // Reset in the middle of a fetch while the CPU tries to write.
    cyc(); line_start = 1'b1; row = 5'd0;
    cyc(); line_start = 1'b0;
    cyc(); resetN = 1'b0; cpu_req = 1'b1; cpu_we = 1'b1; cpu_addr = 9'd9; cpu_wdata = 16'hBEEF;
    smp(); check("t5_we_forced", 32'(ram_we), 0); check("t5_busy_pre", 32'(busy), 1);
    cyc(); smp();
    check("t5_busy", 32'(busy), 0); check("t5_done", 32'(done), 0);
    check("t5_overrun", 32'(overrun), 0); check("t5_front", 32'(buf_rdata), 0);
    check("t5_we", 32'(ram_we), 0);
    cyc(); resetN = 1'b1; cpu_req = 1'b0; cpu_we = 1'b0;
    cyc(); smp();
    check("t5_no_resume", 32'(busy), 0); check("t5_mem_intact", 32'(mem[9]), 32'hA009);

    // Normal CPU write passes through the mux.
    cyc(); cpu_req = 1'b1; cpu_we = 1'b1; cpu_addr = 9'd20; cpu_wdata = 16'h5A5A;
    smp(); check("cpu_we_pass", 32'(ram_we), 1); check("cpu_wdata_pass", 32'(ram_wdata), 32'h5A5A);
    cyc(); cpu_req = 1'b0; cpu_we = 1'b0;
    smp(); check("cpu_write_mem", 32'(mem[20]), 32'h5A5A);

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
